// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and byte-level helpers
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef logic [AES_BLK_W-1:0] aes_block_t;
    typedef aes_block_t aes_rkeys_t [0:AES_NR];

    typedef enum logic [1:0] {IDLE, BUSY, DONE} aes_dec_state_e;

    localparam logic [0:2047] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] AES_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return AES_SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return AES_INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit GF(2^8) constant; enough for the InvMixColumns coefficients.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? a2 : 8'h00) ^ (m[2] ? a4 : 8'h00) ^ (m[3] ? a8 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_block_t state,
    input  aes_block_t rkey,
    input  aes_block_t key_first,
    input  logic       first,
    input  logic       last,
    output aes_block_t next_state
);

    always_comb begin
        aes_block_t pre, sr, x, mix;
        logic [7:0] a0, a1, a2, a3;
        pre = first ? (state ^ key_first) : state;
        sr  = '0;
        // Byte 4*c+r sits at bits [127-8*(4*c+r) -: 8]; row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = pre[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        x = '0;
        for (int i = 0; i < 16; i++) x[127-8*i -: 8] = inv_sub_byte(sr[127-8*i -: 8]);
        x   = x ^ rkey;
        mix = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            mix[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
            mix[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
            mix[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
            mix[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        end
        next_state = last ? x : mix;
    end

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - combinational AES-128 key schedule producing K0..K10
module key_expansion
    import aes_pkg::*;
(
    input  aes_block_t key,
    output aes_rkeys_t rkeys
);

    function automatic aes_rkeys_t expand(input aes_block_t k);
        aes_rkeys_t  rk;
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sub_byte(t[23:16]) ^ rcon, sub_byte(t[15:8]), sub_byte(t[7:0]), sub_byte(t[31:24])};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= AES_NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    assign rkeys = expand(key);

endmodule

// File: rtl/aes_128_dec_iter.sv
// rtl/aes_128_dec_iter.sv - iterative AES-128 decryptor, one inverse round per clock
module aes_128_dec_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_bus,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_bus
);

    aes_dec_state_e state;
    logic [3:0]     rnd_q;
    logic [3:0]     rnd_eff;
    aes_block_t     state_q;
    aes_block_t     key_q;
    aes_block_t     round_out;
    aes_rkeys_t     rkeys;

    // Unreachable counter values 10..15 fall back to the first inverse round.
    assign rnd_eff = (rnd_q > 4'd9) ? 4'd9 : rnd_q;
    assign out_bus = state_q;

    key_expansion u_key_expansion (
        .key   (key_q),
        .rkeys (rkeys)
    );

    aes_inv_round u_inv_round (
        .state      (state_q),
        .rkey       (rkeys[rnd_eff]),
        .key_first  (rkeys[AES_NR]),
        .first      (rnd_eff == 4'd9),
        .last       (rnd_eff == 4'd0),
        .next_state (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rnd_q     <= 4'd0;
            state_q   <= '0;
            key_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= in_bus;
                        key_q    <= key;
                        rnd_q    <= 4'd9;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    state_q <= round_out;
                    if (rnd_eff == 4'd0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rnd_q <= rnd_eff - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
